backprop_step1_ctrl: RTL

Sequencer for the output-layer weight-update datapath (backprop_step1). It takes one start request carrying target t1 and output sigmoid h4, then issues weight indices 0..NUM_WEIGHTS-1 to the shared pipelined datapath, one per cycle, and reads h_i and w_i from the weight/activation store by index. It also tracks each issued index through a fixed-latency valid pipe and writes each w_update back to the store. It sits between the training FSM (start/done) and the weight store plus datapath.

---
 rtl/backprop_step1_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/backprop_step1_ctrl.sv
// Sequencer for the output-layer weight update: latches t1/h4, issues weight
// indices to the shared datapath and writes each w_update back after a fixed latency.
module backprop_step1_ctrl #(
  parameter int NUM_WEIGHTS  = 3,
  parameter int IDX_W        = 2,
  parameter int PIPE_LATENCY = 8,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] target_in,
  input  logic [DATA_W-1:0] osig_in,
  output logic [DATA_W-1:0] target_q,
  output logic [DATA_W-1:0] osig_q,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              issue_valid,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WEIGHTS - 1);

  logic [1:0]                         state;
  logic [PIPE_LATENCY-1:0]            vld_pipe;
  logic [PIPE_LATENCY-1:0][IDX_W-1:0] idx_pipe;

  // The w_update word is wired from the datapath straight into the store;
  // this block only times the write strobe.
  logic unused_wb;
  assign unused_wb = ^wb_data;

  assign issue_valid = (state == S_ISSUE);
  assign busy        = (state == S_ISSUE) || (state == S_DRAIN);
  assign done        = (state == S_DONE);
  assign wr_en       = vld_pipe[PIPE_LATENCY-1];
  assign wr_idx      = idx_pipe[PIPE_LATENCY-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      target_q <= '0;
      osig_q   <= '0;
      rd_idx   <= '0;
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      // Shadow of the datapath pipeline: tags each issued index with its latency.
      vld_pipe[0] <= issue_valid;
      idx_pipe[0] <= rd_idx;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            target_q <= target_in;
            osig_q   <= osig_in;
            rd_idx   <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (rd_idx == LAST_IDX) state <= S_DRAIN;
          else                    rd_idx <= rd_idx + 1'b1;
        end
        S_DRAIN: begin
          // Indices come out in order, so the last index written means the pipe is empty.
          if (wr_en && (wr_idx == LAST_IDX)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
